// File: rtl/cic_interp.sv
// cic_interp: comb-then-integrator interpolator, RATE x upsampling with unity DC gain; define CIC_INTERP_SAT_EN to clamp the output instead of wrapping
module cic_interp #(
  parameter int RATE   = 16,
  parameter int STAGES = 3,
  parameter int WIDTH  = 28
) (
  input  logic             i_clock_in,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_signal_in,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_signal_out,
  output logic             o_out_valid,
  output logic             o_underrun
);
  localparam int LR    = $clog2(RATE);
  localparam int IW    = WIDTH + STAGES*LR + STAGES;
  localparam int SHIFT = (STAGES-1)*LR;
  logic [LR-1:0]    r_ph;
  logic [IW-1:0]    r_d [STAGES];
  logic [IW-1:0]    r_i [STAGES];
  logic [IW-1:0]    w_c [STAGES+1];
  logic             w_slot;
  logic             w_acc;
  logic [WIDTH-1:0] w_out;
  assign w_slot     = i_enable && (r_ph == '0);
  assign w_acc      = w_slot && i_in_valid;
  assign o_in_ready = w_slot;
  // comb chain at input rate; an empty slot replays the last sample so the first difference is zero
  always_comb begin
    w_c[0] = w_acc ? {{(IW-WIDTH){i_signal_in[WIDTH-1]}}, i_signal_in} : r_d[0];
    for (int k = 0; k < STAGES; k++) w_c[k+1] = w_c[k] - r_d[k];
  end
`ifdef CIC_INTERP_SAT_EN
  localparam logic signed [IW-1:0] MAXV = {{(IW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = ~MAXV;
  logic signed [IW-1:0] w_sh;
  assign w_sh = $signed(r_i[STAGES-1]) >>> SHIFT;
  // clamp the gain-corrected integrator output to the signed output range
  always_comb w_out = (w_sh > MAXV) ? MAXV[WIDTH-1:0] : (w_sh < MINV) ? MINV[WIDTH-1:0] : w_sh[WIDTH-1:0];
`else
  assign w_out = r_i[STAGES-1][WIDTH-1+SHIFT:SHIFT];
`endif
  // phase, comb delays, zero-stuffed integrators and the output register all hold while enable is low
  always_ff @(posedge i_clock_in or posedge i_reset) begin
    if (i_reset) begin
      r_ph         <= '0;
      o_signal_out <= '0;
      o_out_valid  <= 1'b0;
      o_underrun   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_d[k] <= '0;
        r_i[k] <= '0;
      end
    end else begin
      o_out_valid <= i_enable;
      if (i_enable) begin
        r_ph         <= r_ph + 1'b1;
        o_signal_out <= w_out;
        r_i[0]       <= r_i[0] + (w_slot ? w_c[STAGES] : '0);
        for (int k = 1; k < STAGES; k++) r_i[k] <= r_i[k] + r_i[k-1];
        if (w_slot) begin
          for (int k = 0; k < STAGES; k++) r_d[k] <= w_c[k];
          if (!i_in_valid) o_underrun <= 1'b1;
        end
      end
    end
  end
endmodule
